fifo_burst_reader: RTL
======================

Name: fifo_burst_reader

Overview:
Read-side engine for the 16-deep fifo. Watches fifo_count. Once a full burst is buffered, it drives fifo_ren to pop BURST_LEN words. Popped words go out on a valid/ready stream with a last-beat flag. Sits between the fifo read port and a downstream burst consumer.

Parameters:
DATA_W, 8, width of fifo_rdata / m_data
COUNT_W, 4, width of fifo_count
BURST_LEN, 4, words per burst; legal 1..15 (fifo count saturates at 15)
TIMEOUT, 15, IDLE cycles with a partial fill before flushing (used only with TIMEOUT_EN)

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous, active-high reset
fifo_count  in  COUNT_W  fifo occupancy
fifo_empty  in  1  fifo empty flag
fifo_rdata  in  DATA_W  fifo read data; combinational from raddr, valid in the same cycle as fifo_ren
fifo_ren  out  1  pop request to fifo
m_valid  out  1  output word valid
m_data  out  DATA_W  output word
m_last  out  1  final beat of the burst, qualified by m_valid
m_ready  in  1  consumer accepts the word when m_valid && m_ready
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, any cycle, including mid-burst):
  - state=IDLE; m_valid=0, m_data=0, m_last=0, busy=0; all counters 0.
  - Any held word is dropped.
  - fifo_ren=0 combinationally while rst=1.
- States: IDLE, BURST, DRAIN.
- IDLE:
  - fifo_ren=0.
  - If fifo_count >= BURST_LEN at posedge: burst_len_q <= BURST_LEN, issued <= 0, go BURST.
- BURST:
  - fifo_ren = !fifo_empty && issued < burst_len_q && (!m_valid || m_ready).
  - On each ren edge: m_data <= fifo_rdata, m_valid <= 1, issued += 1, m_last <= (issued+1 == burst_len_q).
  - When issued reaches burst_len_q, go DRAIN.
- DRAIN:
  - fifo_ren=0.
  - On m_valid && m_ready with m_last=1: m_valid <= 0, m_last <= 0, go IDLE.
- Accept without a new pop: m_valid <= 0 (m_last unchanged until next load).
- Output stability: while m_valid && !m_ready, m_data/m_last/m_valid hold.
- Latency:
  - Threshold sampled at edge t. BURST from t+1; fifo_ren high during cycle t+1; m_valid high from edge t+2.
  - With m_ready=1 continuously: one beat per cycle; BURST_LEN pops in BURST_LEN consecutive cycles.
  - Earliest return to IDLE: edge t+BURST_LEN+2. Next burst may start from there.
- Boundaries:
  - fifo_empty mid-burst: ren held low, burst stalls, no beat skipped. Cannot occur in normal operation; handled anyway.
  - Writer overwrite while full: the reader does not compensate. Data popped is whatever the fifo presents.
  - issued width: enough bits to hold 15 (4 bits); no wrap.
  - m_ready high while m_valid=0: ignored.

Optional Feature:
Macro TIMEOUT_EN.
- Defined:
  - In IDLE, idle_cnt increments each cycle with !fifo_empty && fifo_count < BURST_LEN. It clears otherwise, and on leaving IDLE.
  - When idle_cnt == TIMEOUT-1 and the fifo is still non-empty: burst_len_q <= fifo_count, go BURST. This is a short burst; m_last is on its final beat.
  - A full-threshold start in the same cycle takes priority and uses BURST_LEN.
- Undefined: idle_cnt is absent; partial fills are never drained; burst_len_q is always BURST_LEN.

Test Plan:
- Reset then write 4 words A1..A4, m_ready=1 -> fifo_ren high 4 consecutive cycles; m_data A1,A2,A3,A4; m_last only on A4; busy drops the cycle after A4 is accepted.
- Burst of 4 with m_ready low 3 cycles after the first beat -> m_data=A1 held stable 3 cycles; no extra pops; remaining beats follow once m_ready=1.
- 8 words written back-to-back -> two bursts of 4; second starts 1 cycle after return to IDLE; m_last on beats 4 and 8.
- Assert rst during the 3rd beat -> m_valid=0, fifo_ren=0 immediately; after release, with fifo_count=1, stays IDLE.
- TIMEOUT_EN, write 2 words, no more -> after 15 idle cycles a 2-beat burst; m_last on the 2nd beat; without the macro, stays IDLE indefinitely.
- BURST_LEN=15, fifo filled to 15 -> 15 pops; fifo_empty after the last; no pop while empty.

Source files
------------

// File: rtl/fifo_burst_reader.sv
// fifo_burst_reader: pops BURST_LEN-word bursts from a fifo onto a valid/ready stream; define TIMEOUT_EN to flush partial fills after TIMEOUT idle cycles
module fifo_burst_reader #(
    parameter int DATA_W    = 8,
    parameter int COUNT_W   = 4,
    parameter int BURST_LEN = 4,
    parameter int TIMEOUT   = 15
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COUNT_W-1:0] fifo_count,
    input  logic               fifo_empty,
    input  logic [DATA_W-1:0]  fifo_rdata,
    output logic               fifo_ren,
    output logic               m_valid,
    output logic [DATA_W-1:0]  m_data,
    output logic               m_last,
    input  logic               m_ready,
    output logic               busy
);
    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;
    localparam logic [COUNT_W-1:0] BL = COUNT_W'(BURST_LEN);
    state_t state, state_n;
    logic [COUNT_W-1:0] issued, issued_inc, burst_len_q;
    logic full_start, timeout_start;
    assign full_start = fifo_count >= BL;
    assign issued_inc = issued + COUNT_W'(1);
    assign busy       = state != IDLE;
`ifdef TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT + 1);
    logic [IW-1:0] idle_cnt;
    assign timeout_start = !fifo_empty && fifo_count != '0 && idle_cnt == IW'(TIMEOUT - 1);
    // Count consecutive IDLE cycles holding a partial fill; anything else restarts the count
    always_ff @(posedge clk or posedge rst)
        if (rst) idle_cnt <= '0;
        else idle_cnt <= (state == IDLE && !full_start && !timeout_start && !fifo_empty) ? idle_cnt + IW'(1) : '0;
`else
    assign timeout_start = 1'b0;
`endif
    // State register
    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= state_n;
    // Next state and pop request; a pop only happens when the output register is free or being accepted
    always_comb begin
        state_n  = state;
        fifo_ren = 1'b0;
        case (state)
            IDLE:    state_n = (full_start || timeout_start) ? BURST : IDLE;
            BURST: begin
                fifo_ren = !rst && !fifo_empty && issued < burst_len_q && (!m_valid || m_ready);
                state_n  = (fifo_ren && issued_inc == burst_len_q) ? DRAIN : BURST;
            end
            DRAIN:   state_n = (m_valid && m_ready && m_last) ? IDLE : DRAIN;
            default: state_n = IDLE;
        endcase
    end
    // Burst bookkeeping and the output register; a word waiting on m_ready holds unchanged
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            issued      <= '0;
            burst_len_q <= '0;
            m_valid     <= 1'b0;
            m_data      <= '0;
            m_last      <= 1'b0;
        end else begin
            if (state == IDLE && state_n == BURST) begin
                issued      <= '0;
                burst_len_q <= full_start ? BL : fifo_count;
            end
            if (fifo_ren) begin
                m_data  <= fifo_rdata;
                m_valid <= 1'b1;
                issued  <= issued_inc;
                m_last  <= issued_inc == burst_len_q;
            end else if (m_valid && m_ready) begin
                m_valid <= 1'b0;
                m_last  <= (state == DRAIN) ? 1'b0 : m_last;
            end
        end
    end
endmodule
